// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..n-1 (n >= 2).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_piso_shift_reg.sv
// Parallel-load, shift-right register with serial input at the MSB.
module piso_shift_reg
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one full-adder slice.
// Optional signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t          state, state_nxt;
  logic            load, shift, last;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            s, c;
  logic [WIDTH-1:0] a_q, b_q;
  logic            unused_b_upper;

  assign unused_b_upper = ^b_q[WIDTH-1:1];
  assign last = (cnt == CW'(WIDTH - 1));
  assign {c, s} = {1'b0, a_q[0]} + {1'b0, b_q[0]} + {1'b0, carry};

  piso_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .d     (a),
    .sin   (s),
    .q     (a_q)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .d     (b ^ {WIDTH{sub}}),
    .sin   (1'b0),
    .q     (b_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result is captured into its own register on the last shift so that the
  // outputs stay stable while a back-to-back operation reuses the A register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      carry <= sub;
      cnt   <= '0;
    end else if (shift) begin
      carry <= c;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        sum  <= {s, a_q[WIDTH-1:1]};
        cout <= c;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf  <= carry ^ c;
`endif
      end
    end
  end

endmodule
